mul_seq: RTL and testbench
==========================

Name: mul_seq

Overview:
- Iterative 64x64 shift-add multiply sequencer for the execute stage of the pipelined LEGv8 core.
- Handles MUL (low 64 bits of the product) and UMULH (high 64 bits of the unsigned product).
- Holds the pipeline stalled while it iterates, then presents the result for one cycle.
- Sits beside the ALU and its control decoder; the EX-stage mux selects its result when done=1.

Parameters:
- N, 64, operand width in bits; the product is 2N bits.
- MUL_OP, 11'b10011011000, funct encoding for MUL.
- UMULH_OP, 11'b10011011110, funct encoding for UMULH.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request from ID/EX; sampled in IDLE or DONE.
- funct  in  11  instruction opcode field, sampled with start.
- a  in  N  multiplicand (Rn value), sampled with start.
- b  in  N  multiplier (Rm value), sampled with start.
- flush  in  1  pipeline flush; aborts any operation in flight.
- stall  out  1  holds IF/ID/EX; combinational.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; result valid.
- result  out  N  MUL: low half of product; UMULH: high half.
- illegal  out  1  one-cycle pulse when start arrives with an unsupported funct.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; acc, mcand, cnt, result all 0; busy, done, illegal all 0.
- State: acc (2N+1 bits: carry, hi, lo), mcand (N), op (1), cnt (log2(N)+1 bits).
- A start is "accepted" when start=1 and funct is MUL_OP or UMULH_OP, in IDLE or DONE.
- IDLE:
  - Accepted start -> load acc={0, N'b0, b}, mcand=a, op=(funct==UMULH_OP), cnt=0 -> RUN.
  - start=1 with any other funct -> illegal=1 next cycle, stay IDLE.
- RUN, one iteration per cycle:
  - sum = hi + (acc[0] ? mcand : 0), N+1 bits.
  - acc <= {sum, lo} >> 1; cnt <= cnt+1.
  - When cnt==N-1 -> DONE.
- DONE, one cycle:
  - done=1; result = op ? acc[2N-1:N] : acc[N-1:0], registered and held until the next DONE or reset.
  - Accepted start -> reload and go to RUN (back-to-back).
  - Otherwise -> IDLE.
- Latency: start accepted at edge 0 -> busy=1 for cycles 1..N, done=1 in cycle N+1. Total N+1 cycles.
- Stall:
  - stall = (state==RUN) | (start & accepted-funct & state!=RUN & !flush).
  - Deasserts in the DONE cycle so the pipeline captures result.
- flush:
  - Has priority over start in every state.
  - Next state is IDLE; no done pulse; result is unchanged; busy drops next cycle.
- start while in RUN: ignored. The pipeline is stalled, so the request persists and is accepted in DONE.
- Arithmetic is unsigned with no overflow indication. The carry bit prevents loss on hi+mcand.
- Operands of zero or all-ones require no special cases; latency is always N+1.

Test Plan:
- a=3, b=5, funct=MUL_OP, start pulse -> busy for 64 cycles, done at cycle 65, result=15, stall deasserted in the done cycle.
- a=b=64'hFFFF_FFFF_FFFF_FFFF, UMULH -> result=64'hFFFF_FFFF_FFFF_FFFE. Same operands with MUL -> result=64'h1.
- Back-to-back: start held with MUL 7x6, then UMULH 2^63 x 4 accepted in the DONE cycle -> done pulses at cycles 65 and 130, results 42 then 2.
- flush asserted at RUN cycle 20 -> IDLE next cycle, no done, busy=0, result keeps its prior value. A new MUL 2x2 afterwards returns 4.
- reset pulled low at RUN cycle 10 -> all outputs 0 immediately (asynchronous). After release, start with funct=11'b10001011000 (ADD) -> illegal pulse, state stays IDLE, stall=0.
- Randomized: 1000 operand pairs, MUL/UMULH checked against a 128-bit reference product.

Source files
------------

// File: rtl/mul_seq_if.sv
// Request/response bundle between the EX stage and the shift-add multiply sequencer.
// The pipeline side drives the master modport; the sequencer uses the slave modport.
interface mul_seq_if #(
    parameter int N = 64
);
    logic          start;
    logic [10:0]   funct;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          flush;
    logic          stall;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          illegal;

    modport master (
        output start, funct, a, b, flush,
        input  stall, busy, done, result, illegal
    );

    modport slave (
        input  start, funct, a, b, flush,
        output stall, busy, done, result, illegal
    );
endinterface

// File: rtl/mul_seq.sv
// Iterative N x N shift-add multiplier for LEGv8 MUL / UMULH. It retires one multiplier bit
// per cycle, stalls the pipeline while it runs, and then pulses done for one cycle.
module mul_seq #(
    parameter int          N        = 64,
    parameter logic [10:0] MUL_OP   = 11'b10011011000,
    parameter logic [10:0] UMULH_OP = 11'b10011011110
) (
    input  logic     clk,
    input  logic     reset,
    mul_seq_if.slave bus
);
    localparam int CW = $clog2(N) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [2*N:0]  acc;        // {carry, hi, lo}; lo starts as the multiplier
    logic [2*N:0]  acc_step;
    logic [N:0]    sum;
    logic [N-1:0]  mcand;
    logic [N-1:0]  result_q;
    logic [CW-1:0] cnt;
    logic          op;
    logic          illegal_q;
    logic          fn_ok;
    logic          can_take;
    logic          accept;
    logic          last;

    always_comb begin
        fn_ok    = (bus.funct == MUL_OP) || (bus.funct == UMULH_OP);
        can_take = (state == S_IDLE) || (state == S_DONE);
        accept   = bus.start && fn_ok && can_take && !bus.flush;
        last     = (state == S_RUN) && (cnt == CW'(N - 1));
        // The carry bit is always clear after a shift, so hi + mcand fits in N+1 bits.
        sum      = acc[2*N:N] + (acc[0] ? {1'b0, mcand} : {(N+1){1'b0}});
        acc_step = {sum, acc[N-1:0]} >> 1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            acc       <= '0;
            mcand     <= '0;
            cnt       <= '0;
            op        <= 1'b0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= bus.start && !fn_ok && can_take && !bus.flush;
            if (bus.flush) begin
                state <= S_IDLE;
            end else if (accept) begin
                acc   <= {1'b0, {N{1'b0}}, bus.b};
                mcand <= bus.a;
                op    <= (bus.funct == UMULH_OP);
                cnt   <= '0;
                state <= S_RUN;
            end else begin
                case (state)
                    S_RUN: begin
                        acc <= acc_step;
                        cnt <= cnt + 1'b1;
                        // Capture from the final step so result is valid throughout DONE.
                        if (last) begin
                            state    <= S_DONE;
                            result_q <= op ? acc_step[2*N-1:N] : acc_step[N-1:0];
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.stall   = (state == S_RUN) || accept;
    assign bus.busy    = (state == S_RUN);
    assign bus.done    = (state == S_DONE);
    assign bus.result  = result_q;
    assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: expected results are queued at issue and compared
// when done pulses.
module tb_mul_seq;
    localparam logic [10:0] MUL_OP   = 11'b10011011000;
    localparam logic [10:0] UMULH_OP = 11'b10011011110;
    localparam logic [10:0] ADD_OP   = 11'b10001011000;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mul_seq_if #(.N(64)) bus ();
    mul_seq #(.N(64)) dut (.clk(clk), .reset(reset), .bus(bus));

    int errors = 0;
    int checks = 0;
    logic [63:0] sb_q[$];

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && bus.done === 1'b1) begin
            if (sb_q.size() == 0) chk("unexp_done", bus.done, 0);
            else                  chk("result", bus.result, sb_q.pop_front());
        end
    end

    // Caller sits at a negedge; start is dropped just after the accepting edge.
    task automatic issue(input logic [10:0] fn, input logic [63:0] x, input logic [63:0] y);
        bus.start = 1'b1; bus.funct = fn; bus.a = x; bus.b = y;
        #1 chk("stall_req", bus.stall, 1);
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int cyc = 0;
        int busy_n = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy) busy_n++;
        end while (!bus.done && cyc < 300);
        chk({tag, "_lat"}, cyc, 65);
        chk({tag, "_busy"}, busy_n, 64);
    endtask

    function automatic logic [63:0] ref_mul(input logic uh, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] p;
        p = {64'd0, x} * {64'd0, y};
        return uh ? p[127:64] : p[63:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.funct = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_illegal", bus.illegal, 0);
        chk("rst_result", bus.result, 0);
        chk("rst_stall", bus.stall, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic MUL with latency, busy length and stall release in the done cycle
        sb_q.push_back(64'd15);
        issue(MUL_OP, 64'd3, 64'd5);
        wait_done("mul3x5");
        chk("stall_in_done", bus.stall, 0);
        @(negedge clk);

        sb_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        issue(UMULH_OP, '1, '1);
        wait_done("umulh_ones");
        @(negedge clk);
        sb_q.push_back(64'h1);
        issue(MUL_OP, '1, '1);
        wait_done("mul_ones");
        @(negedge clk);

        // Back-to-back: start held, second request accepted in the DONE cycle
        sb_q.push_back(64'd42);
        sb_q.push_back(64'd2);
        bus.start = 1'b1; bus.funct = MUL_OP; bus.a = 64'd7; bus.b = 64'd6;
        @(posedge clk); #1;
        bus.funct = UMULH_OP; bus.a = 64'h8000_0000_0000_0000; bus.b = 64'd4;
        wait_done("b2b_first");
        chk("b2b_stall_done", bus.stall, 1);
        @(posedge clk); #1 bus.start = 1'b0;
        wait_done("b2b_second");
        @(negedge clk);

        // Flush mid-run: no done pulse and result keeps its prior value
        issue(MUL_OP, 64'd9, 64'd9);
        repeat (20) @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", bus.busy, 0);
        chk("flush_done", bus.done, 0);
        chk("flush_result", bus.result, 64'd2);
        repeat (70) @(negedge clk);
        chk("flush_result_hold", bus.result, 64'd2);
        sb_q.push_back(64'd4);
        issue(MUL_OP, 64'd2, 64'd2);
        wait_done("after_flush");
        @(negedge clk);

        // Asynchronous reset mid-run, then an unsupported funct
        issue(MUL_OP, 64'd5, 64'd5);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_done", bus.done, 0);
        chk("arst_stall", bus.stall, 0);
        chk("arst_result", bus.result, 0);
        chk("arst_illegal", bus.illegal, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.funct = ADD_OP; bus.a = 64'd1; bus.b = 64'd1;
        #1 chk("ill_stall", bus.stall, 0);
        @(posedge clk); #1 bus.start = 1'b0;
        @(negedge clk);
        chk("ill_pulse", bus.illegal, 1);
        chk("ill_busy", bus.busy, 0);
        @(negedge clk);
        chk("ill_clear", bus.illegal, 0);
        chk("ill_idle", bus.busy, 0);

        // Randomized operands against a 128-bit reference product
        for (int i = 0; i < 1000; i++) begin
            logic [63:0] ra, rb;
            logic uh;
            int sel;
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            uh  = $urandom_range(0, 1) == 1;
            sel = $urandom_range(0, 15);
            if (sel == 0) ra = '0;
            if (sel == 1) rb = '1;
            if (sel == 2) ra = '1;
            sb_q.push_back(ref_mul(uh, ra, rb));
            issue(uh ? UMULH_OP : MUL_OP, ra, rb);
            wait_done("rnd");
        end

        repeat (3) @(negedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
